// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one byte-wide RAM port between instruction fetch (IF) and the MEM
// stage. Each granted request becomes 1, 2 or 4 single-byte RAM accesses in
// little-endian order. Read data is assembled and then sign- or zero-extended.
// Per-requester stall outputs hold the pipeline while a request is
// outstanding.
//
// Optional build macro: ARB_RR_EN
//   defined   - round-robin on simultaneous requests (last-owner register)
//   undefined - fixed MEM-over-IF priority
//
// Ports:
//   clk_in, rst_n_in      clock (rising edge), synchronous active-low reset
//   rdy_in                global ready; low freezes all state, gates ram_wr_out
//   if_req_in/if_addr_in  IF word-read request and byte address
//   if_data_out/done_out  fetched word, one-cycle completion pulse
//   mem_req_in, mem_we_in, mem_size_in, mem_sign_in, mem_addr_in,
//   mem_wdata_in          MEM load/store request
//   mem_rdata_out/done    extended load result, one-cycle completion pulse
//   if_stall_out, mem_stall_out  request pending and not yet done
//   ram_din_in            RAM read data for the address registered last edge
//   ram_dout_out, ram_a_out, ram_wr_out  RAM write data, address, write strobe
module mem_port_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              if_req_in,
    input  logic [31:0]       if_addr_in,
    output logic [31:0]       if_data_out,
    output logic              if_done_out,
    input  logic              mem_req_in,
    input  logic              mem_we_in,
    input  logic [1:0]        mem_size_in,
    input  logic              mem_sign_in,
    input  logic [31:0]       mem_addr_in,
    input  logic [31:0]       mem_wdata_in,
    output logic [31:0]       mem_rdata_out,
    output logic              mem_done_out,
    output logic              if_stall_out,
    output logic              mem_stall_out,
    input  logic [7:0]        ram_din_in,
    output logic [7:0]        ram_dout_out,
    output logic [ADDR_W-1:0] ram_a_out,
    output logic              ram_wr_out
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    // Sign/zero extension of an assembled little-endian load.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  nlast,
                                                input logic        sgn);
        logic [31:0] res;
        case (nlast)
            2'd0:    res = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
            2'd1:    res = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;      // 1 = MEM owns the transaction
    logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
    logic [7:0]          ram_dout_q, ram_dout_d;
    logic                ram_wr_q, ram_wr_d;
    logic [31:0]         if_data_q, if_data_d;
    logic [31:0]         mem_rdata_q, mem_rdata_d;
    logic                if_done_q, if_done_d;
    logic                mem_done_q, mem_done_d;

    // Transaction payload: not reset, only meaningful once accepted.
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [1:0]          nlast_q, nlast_d;      // byte count minus one
    logic                sign_q, sign_d;
    logic [3:0][7:0]     wbytes_q, wbytes_d;
    logic [3:0][7:0]     rbytes_q, rbytes_d;

    logic                accept;
    logic                grant_mem;
    logic [1:0]          cnt_inc;
    logic [3:0][7:0]     rd_word;
    logic [1:0]          mem_nlast;

    // Upper address bits are ignored; addresses wrap modulo 2^ADDR_W.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_in[31:ADDR_W], mem_addr_in[31:ADDR_W]};

    // A done pulse in the current cycle blocks acceptance, which forces the
    // one-cycle gap and keeps a still-asserted request from being re-served.
    assign accept = (state_q == IDLE) && rdy_in && !if_done_q && !mem_done_q &&
                    (if_req_in || mem_req_in);

`ifdef ARB_RR_EN
    logic last_mem_q;   // 1 = MEM was granted most recently

    assign grant_mem = mem_req_in && (!if_req_in || !last_mem_q);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            last_mem_q <= 1'b0;
        end else if (accept) begin
            last_mem_q <= grant_mem;
        end
    end
`else
    assign grant_mem = mem_req_in;
`endif

    always_comb begin
        case (mem_size_in)
            2'd0:    mem_nlast = 2'd0;
            2'd1:    mem_nlast = 2'd1;
            default: mem_nlast = 2'd3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = ram_wr_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        base_d      = base_q;
        nlast_d     = nlast_q;
        sign_d      = sign_q;
        wbytes_d    = wbytes_q;
        rbytes_d    = rbytes_q;

        cnt_inc = cnt_q + 2'd1;
        // Current byte merged straight from the RAM so the final byte does not
        // cost an extra cycle.
        rd_word          = rbytes_q;
        rd_word[cnt_q]   = ram_din_in;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = 2'd0;
                    owner_d = grant_mem;
                    if (grant_mem) begin
                        base_d   = mem_addr_in[ADDR_W-1:0];
                        nlast_d  = mem_nlast;
                        sign_d   = mem_sign_in;
                        wbytes_d = mem_wdata_in;
                    end else begin
                        base_d  = if_addr_in[ADDR_W-1:0];
                        nlast_d = 2'd3;
                        sign_d  = 1'b0;
                    end
                    ram_a_d = base_d;
                    if (grant_mem && mem_we_in) begin
                        state_d    = WR;
                        ram_dout_d = mem_wdata_in[7:0];
                        ram_wr_d   = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                rbytes_d = rd_word;
                if (cnt_q == nlast_q) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = extend_load(rd_word, nlast_q, sign_q);
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = rd_word;
                    end
                end else begin
                    cnt_d   = cnt_inc;
                    ram_a_d = base_q + ADDR_W'(cnt_inc);
                end
            end
            WR: begin
                if (cnt_q == nlast_q) begin
                    state_d    = IDLE;
                    ram_wr_d   = 1'b0;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_inc;
                    ram_a_d    = base_q + ADDR_W'(cnt_inc);
                    ram_dout_d = wbytes_q[cnt_inc];
                end
            end
            default: begin
                state_d  = IDLE;
                ram_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            owner_q     <= 1'b0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            base_q   <= base_d;
            nlast_q  <= nlast_d;
            sign_q   <= sign_d;
            wbytes_q <= wbytes_d;
            rbytes_q <= rbytes_d;
        end
    end

    assign if_data_out   = if_data_q;
    assign if_done_out   = if_done_q;
    assign mem_rdata_out = mem_rdata_q;
    assign mem_done_out  = mem_done_q;
    assign ram_a_out     = ram_a_q;
    assign ram_dout_out  = ram_dout_q;
    assign ram_wr_out    = ram_wr_q && rdy_in;
    assign if_stall_out  = if_req_in && !if_done_q;
    assign mem_stall_out = mem_req_in && !mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a combinational-read RAM model
// and a write log of every strobed RAM write.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 17;

    logic              clk;
    logic              rst_n;
    logic              rdy;
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_data;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic              mem_sign;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              if_stall;
    logic              mem_stall;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .rdy_in        (rdy),
        .if_req_in     (if_req),
        .if_addr_in    (if_addr),
        .if_data_out   (if_data),
        .if_done_out   (if_done),
        .mem_req_in    (mem_req),
        .mem_we_in     (mem_we),
        .mem_size_in   (mem_size),
        .mem_sign_in   (mem_sign),
        .mem_addr_in   (mem_addr),
        .mem_wdata_in  (mem_wdata),
        .mem_rdata_out (mem_rdata),
        .mem_done_out  (mem_done),
        .if_stall_out  (if_stall),
        .mem_stall_out (mem_stall),
        .ram_din_in    (ram_din),
        .ram_dout_out  (ram_dout),
        .ram_a_out     (ram_a),
        .ram_wr_out    (ram_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [0:(1<<ADDR_W)-1];
    assign ram_din = ram[ram_a];

    int                wr_n = 0;
    logic [ADDR_W-1:0] wr_a_log [0:63];
    logic [7:0]        wr_d_log [0:63];

    always @(posedge clk) begin
        if (ram_wr && wr_n < 64) begin
            wr_a_log[wr_n[5:0]] <= ram_a;
            wr_d_log[wr_n[5:0]] <= ram_dout;
            wr_n <= wr_n + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mem_xfer(input string tag, input logic we, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int edges, output int wr_cycles);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_size  = size;
        mem_sign  = sgn;
        mem_addr  = addr;
        mem_wdata = wdata;
        edges     = 0;
        wr_cycles = 0;
        do begin
            tick;
            edges++;
            if (ram_wr) wr_cycles++;
        end while (!mem_done && edges < 20);
        check({tag, "_done"}, 32'(mem_done), 32'd1);
        rdata   = mem_rdata;
        mem_req = 1'b0;
        tick;
        check({tag, "_pulse"}, 32'(mem_done), 32'd0);
    endtask

    // Both requesters raised together; mem_first gives the expected winner.
    task automatic race(input string tag, input logic mem_first);
        logic [31:0] a1, a2, a1_last;
        int          n2, lim;
        mem_req  = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_sign = 1'b0;
        mem_addr = 32'h50;
        if_req   = 1'b1; if_addr = 32'h200;
        a1      = mem_first ? 32'h50 : 32'h200;
        a1_last = mem_first ? 32'h50 : 32'h203;
        a2      = mem_first ? 32'h200 : 32'h50;
        n2      = mem_first ? 4 : 1;
        tick;
        check({tag, "_first_addr"}, 32'(ram_a), a1);
        check({tag, "_if_stall"}, 32'(if_stall), 32'd1);
        lim = 0;
        while (!(mem_first ? mem_done : if_done) && lim < 10) begin
            tick;
            lim++;
        end
        check({tag, "_first_done"}, 32'(mem_first ? mem_done : if_done), 32'd1);
        check({tag, "_other_idle"}, 32'(mem_first ? if_done : mem_done), 32'd0);
        if (mem_first) mem_req = 1'b0; else if_req = 1'b0;
        tick;
        check({tag, "_gap_addr"}, 32'(ram_a), a1_last);
        tick;
        check({tag, "_second_addr"}, 32'(ram_a), a2);
        lim = 0;
        while (!(mem_first ? if_done : mem_done) && lim < 10) begin
            tick;
            lim++;
        end
        check({tag, "_second_lat"}, 32'(lim), 32'(n2));
        check({tag, "_if_data"}, if_data, 32'h12345678);
        check({tag, "_mem_data"}, mem_rdata, 32'h0000007F);
        mem_req = 1'b0;
        if_req  = 1'b0;
        tick;
    endtask

    logic [31:0]       rd;
    int                e, w, start;
    logic [31:0]       v;
    logic [ADDR_W-1:0] ea [4];

    initial begin
        rst_n = 1'b0; rdy = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_sign = 1'b0;
        mem_addr = 32'd0; mem_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) ram[ADDR_W'(i)] = 8'h00;
        ram[ADDR_W'(32'h100)] = 8'h13;
        ram[ADDR_W'(32'h40)]  = 8'h80;
        ram[ADDR_W'(32'h41)]  = 8'h91;
        ram[ADDR_W'(32'h42)]  = 8'h22;
        ram[ADDR_W'(32'h43)]  = 8'h33;
        ram[ADDR_W'(32'h50)]  = 8'h7F;
        ram[ADDR_W'(32'h200)] = 8'h78;
        ram[ADDR_W'(32'h201)] = 8'h56;
        ram[ADDR_W'(32'h202)] = 8'h34;
        ram[ADDR_W'(32'h203)] = 8'h12;
        ram[ADDR_W'(32'h1FFFE)] = 8'h11;
        ram[ADDR_W'(32'h1FFFF)] = 8'h22;
        ram[ADDR_W'(32'h0)]     = 8'h33;
        ram[ADDR_W'(32'h1)]     = 8'h44;

        // Reset state
        tick; tick;
        check("rst_if_done", 32'(if_done), 32'd0);
        check("rst_mem_done", 32'(mem_done), 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_ram_a", 32'(ram_a), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        rst_n = 1'b1;

        // IF word fetch at 0x100
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        check("if_stall_req", 32'(if_stall), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick;
            check("if_addr_seq", 32'(ram_a), 32'h100 + 32'(k));
            check("if_done_early", 32'(if_done), 32'd0);
        end
        tick;
        check("if_done", 32'(if_done), 32'd1);
        check("if_data", if_data, 32'h00000013);
        check("if_stall_done", 32'(if_stall), 32'd0);
        if_req = 1'b0;
        tick;
        check("if_done_pulse", 32'(if_done), 32'd0);

        // Loads with extension
        mem_xfer("lb_s", 1'b0, 2'd0, 1'b1, 32'h40, 32'd0, rd, e, w);
        check("lb_s_data", rd, 32'hFFFFFF80);
        check("lb_s_lat", 32'(e), 32'd2);
        mem_xfer("lb_u", 1'b0, 2'd0, 1'b0, 32'h40, 32'd0, rd, e, w);
        check("lb_u_data", rd, 32'h00000080);
        check("lb_u_lat", 32'(e), 32'd2);
        mem_xfer("lh_s", 1'b0, 2'd1, 1'b1, 32'h40, 32'd0, rd, e, w);
        check("lh_s_data", rd, 32'hFFFF9180);
        check("lh_s_lat", 32'(e), 32'd3);
        mem_xfer("lh_u", 1'b0, 2'd1, 1'b0, 32'h40, 32'd0, rd, e, w);
        check("lh_u_data", rd, 32'h00009180);
        mem_xfer("lw", 1'b0, 2'd3, 1'b1, 32'h40, 32'd0, rd, e, w);
        check("lw_data", rd, 32'h33229180);
        check("lw_lat", 32'(e), 32'd5);
        check("if_data_hold", if_data, 32'h00000013);

        // Word store
        start = wr_n;
        mem_xfer("sw", 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, rd, e, w);
        check("sw_lat", 32'(e), 32'd5);
        check("sw_wr_cycles", 32'(w), 32'd4);
        check("sw_log_n", 32'(wr_n - start), 32'd4);
        v = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            check("sw_log_a", 32'(wr_a_log[6'(start + k)]), 32'h20 + 32'(k));
            check("sw_log_d", 32'(wr_d_log[6'(start + k)]), 32'(v[8*k +: 8]));
        end
        check("rdata_hold", mem_rdata, 32'h33229180);

        // Byte store
        start = wr_n;
        mem_xfer("sb", 1'b1, 2'd0, 1'b0, 32'h30, 32'h000000A5, rd, e, w);
        check("sb_wr_cycles", 32'(w), 32'd1);
        check("sb_lat", 32'(e), 32'd2);
        check("sb_log_a", 32'(wr_a_log[6'(start)]), 32'h30);
        check("sb_log_d", 32'(wr_d_log[6'(start)]), 32'hA5);

        // Simultaneous requests; MEM was served last
`ifdef ARB_RR_EN
        race("race1", 1'b0);
        race("race2", 1'b0);
`else
        race("race1", 1'b1);
        race("race2", 1'b1);
`endif

        // Word fetch wrapping the top of the address space
        ea[0] = 17'h1FFFE; ea[1] = 17'h1FFFF; ea[2] = 17'h00000; ea[3] = 17'h00001;
        if_req = 1'b1; if_addr = 32'h0003FFFE;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("wrap_addr", 32'(ram_a), 32'(ea[k]));
        end
        tick;
        check("wrap_done", 32'(if_done), 32'd1);
        check("wrap_data", if_data, 32'h44332211);
        if_req = 1'b0;
        tick;

        // IF was served last: MEM wins in both arbitration modes
        race("race3", 1'b1);

        // Freeze mid-store
        start = wr_n;
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h60;
        mem_wdata = 32'h01020304;
        tick;
        check("frz_a0", 32'(ram_a), 32'h60);
        check("frz_wr0", 32'(ram_wr), 32'd1);
        check("frz_d0", 32'(ram_dout), 32'h04);
        tick;
        check("frz_a1", 32'(ram_a), 32'h61);
        check("frz_d1", 32'(ram_dout), 32'h03);
        rdy = 1'b0;
        #1;
        check("frz_wr_gate", 32'(ram_wr), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("frz_a_hold", 32'(ram_a), 32'h61);
            check("frz_wr_low", 32'(ram_wr), 32'd0);
            check("frz_no_done", 32'(mem_done), 32'd0);
        end
        rdy = 1'b1;
        #1;
        check("frz_wr_resume", 32'(ram_wr), 32'd1);
        tick;
        check("frz_a2", 32'(ram_a), 32'h62);
        check("frz_d2", 32'(ram_dout), 32'h02);
        tick;
        check("frz_a3", 32'(ram_a), 32'h63);
        check("frz_d3", 32'(ram_dout), 32'h01);
        tick;
        check("frz_done", 32'(mem_done), 32'd1);
        check("frz_wr_end", 32'(ram_wr), 32'd0);
        mem_req = 1'b0;
        tick;
        check("frz_log_n", 32'(wr_n - start), 32'd4);
        v = 32'h01020304;
        for (int k = 0; k < 4; k++) begin
            check("frz_log_a", 32'(wr_a_log[6'(start + k)]), 32'h60 + 32'(k));
            check("frz_log_d", 32'(wr_d_log[6'(start + k)]), 32'(v[8*k +: 8]));
        end

        // Reset mid-read
        if_req = 1'b1; if_addr = 32'h100;
        tick;
        tick;
        check("mrst_pre_a", 32'(ram_a), 32'h101);
        rst_n = 1'b0; if_req = 1'b0;
        tick;
        check("mrst_ram_a", 32'(ram_a), 32'd0);
        check("mrst_if_done", 32'(if_done), 32'd0);
        check("mrst_mem_done", 32'(mem_done), 32'd0);
        check("mrst_if_data", if_data, 32'd0);
        check("mrst_mem_rdata", mem_rdata, 32'd0);
        check("mrst_ram_wr", 32'(ram_wr), 32'd0);
        check("mrst_ram_dout", 32'(ram_dout), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("mrst_no_done", 32'(if_done), 32'd0);
            check("mrst_idle_a", 32'(ram_a), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.
- Each granted request is sequenced as 1, 2 or 4 single-byte RAM accesses, little-endian.
- Produces the per-requester stall signals that hold the IF and EX/MEM pipeline registers while an access is outstanding.
- Returns assembled read data, sign- or zero-extended.

Parameters:
ADDR_W, 17, width of RAM address bus; all byte addresses wrap modulo 2^ADDR_W

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  synchronous active-low reset
rdy_in  input  1  global ready; low freezes the block
if_req_in  input  1  IF word-read request, held until if_done_out
if_addr_in  input  32  IF byte address (low ADDR_W bits used)
if_data_out  output  32  fetched instruction word
if_done_out  output  1  one-cycle pulse, if_data_out valid
mem_req_in  input  1  MEM request, held until mem_done_out
mem_we_in  input  1  1 = store, 0 = load
mem_size_in  input  2  0 byte, 1 half, 2 word, 3 treated as word
mem_sign_in  input  1  load sign-extend (1) / zero-extend (0)
mem_addr_in  input  32  MEM byte address
mem_wdata_in  input  32  store data, low bytes first
mem_rdata_out  output  32  load result, extended
mem_done_out  output  1  one-cycle pulse, access complete
if_stall_out  output  1  if_req_in && !if_done_out (combinational)
mem_stall_out  output  1  mem_req_in && !mem_done_out (combinational)
ram_din_in  input  8  RAM read data; one-cycle latency after address
ram_dout_out  output  8  RAM write data
ram_a_out  output  ADDR_W  RAM byte address
ram_wr_out  output  1  RAM write strobe; forced 0 while rdy_in low

Behaviour:
- Reset (rst_n_in low at a clock edge; overrides rdy_in): state IDLE, cnt=0, all registered outputs 0.
  - Reset mid-transaction abandons it; a partial store is permitted.
- rdy_in low: no state, counter or output register changes; ram_wr_out gated to 0.
- States: IDLE, RD, WR. Byte count N = 1/2/4 from size; IF always N=4.
- Acceptance (IDLE only, rdy_in high, neither done output high in the current cycle):
  - If mem_req_in is high, grant MEM; otherwise grant IF if if_req_in is high.
  - Latch base address, N, sign, wdata and owner.
  - Done outputs are high on the cycle after completion, so there is a mandatory 1-cycle gap between transactions and the same request is never re-accepted.
- RD:
  - At the accept edge: ram_a_out=base, cnt=0.
  - At each following edge: capture ram_din_in into byte[cnt], cnt++, ram_a_out=base+cnt.
  - At the edge capturing byte N-1: pulse the owner's done, load its data output, return to IDLE.
  - Latency: word read done high after 4 edges past acceptance; byte read after 1.
- WR:
  - At the accept edge: ram_a_out=base, ram_dout_out=wdata[7:0], ram_wr_out=1, cnt=0.
  - At each following edge with cnt<N-1: cnt++, advance address and next byte.
  - At the edge after byte N-1 is driven: ram_wr_out=0, mem_done_out=1, IDLE. Store of N bytes is done after N edges.
- Load extension: bit 8N-1 replicated above byte N-1 if mem_sign_in, else zeros.
  - IF words and word loads are unextended.
- Data outputs hold their last value between transactions; done pulses last exactly 1 cycle.
- ram_a_out holds its last value in IDLE; ram_wr_out is 0 outside WR.
- Address arithmetic is ADDR_W bits; base+cnt wraps (e.g. word at 2^ADDR_W-2 touches ...FE, ...FF, 0, 1).
- Simultaneous requests: MEM wins, IF stalls (unless ARB_RR_EN).
- Request dropped mid-transaction: the transaction completes anyway; done is still pulsed.

Optional Feature:
ARB_RR_EN
- Defined: a 1-bit last-owner register (reset 0 = IF) gives round-robin on simultaneous requests; the requester not served last wins. The register updates at each acceptance.
- Undefined: fixed MEM-over-IF priority, no extra register.

Test Plan:
1. Reset, then IF req, addr 0x100, RAM bytes 13 00 00 00 -> addresses 0x100..0x103, if_done_out after 4 edges, if_data_out=0x00000013, if_stall_out high until done.
2. MEM load byte, sign=1, RAM byte 0x80 -> mem_rdata_out=0xFFFFFF80; repeat with sign=0 -> 0x00000080; done 1 edge after accept.
3. MEM store word 0xDEADBEEF at 0x20 -> ram_wr_out high 4 cycles, bytes EF BE AD DE at 0x20..0x23, mem_done_out the cycle after.
4. IF and MEM req raised same cycle -> MEM served first, IF accepted after 1 idle cycle; with ARB_RR_EN and prior owner MEM -> IF first.
5. Word read at 0x1FFFE (ADDR_W=17) -> addresses 1FFFE, 1FFFF, 00000, 00001.
6. rdy_in low 3 cycles mid-store, then rst_n_in low mid-read -> no address advance and ram_wr_out=0 while frozen; reset returns IDLE with all outputs 0 and no done pulse.
